// File: rtl/project_select_ctrl_pkg.sv
// Shared types and constants for the project select controller.
// Holds the FSM state encoding and the guard counter width.
package project_sel_pkg;

    localparam int CNT_W      = 8;
    localparam int N_PROJ_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/project_select_ctrl_if.sv
// Host-request and project-enable bundle between the request source and the controller.
// The master side is the host; the slave side is project_select_ctrl.
interface project_select_ctrl_if #(
    parameter int N_PROJ = 8,
    parameter int ID_W   = 4
) ();
    logic              sel_valid_i;
    logic [ID_W-1:0]   sel_id_i;
    logic              sel_ready_o;
    logic              disable_i;
    logic [N_PROJ-1:0] active_o;
    logic [ID_W-1:0]   cur_id_o;
    logic              cur_vld_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output sel_valid_i, sel_id_i, disable_i,
        input  sel_ready_o, active_o, cur_id_o, cur_vld_o, busy_o, done_o, err_o
    );

    modport slave (
        input  sel_valid_i, sel_id_i, disable_i,
        output sel_ready_o, active_o, cur_id_o, cur_vld_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/project_select_ctrl_guard_timer.sv
// Guard interval counter: loads a start value, counts down to zero and holds there.
// zero_o is taken straight from the count register.
module guard_timer
    import project_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/project_select_ctrl.sv
// Owns the shared io/LA buses: grants exactly one wrapped project at a time and
// inserts an all-inactive guard interval on every switch.
module project_select_ctrl
    import project_sel_pkg::*;
#(
    parameter int N_PROJ    = 8,
    parameter int ID_W      = 4,
    parameter int GUARD_CYC = 16
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    project_select_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);

    state_t            state_q, state_nx;
    logic [N_PROJ-1:0] active_q, active_nx;
    logic [ID_W-1:0]   cur_id_q, cur_id_nx;
    logic              cur_vld_q, cur_vld_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;
    logic              err_q, err_nx;

    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic sel_ready;
    logic accept;
    logic id_ok;

    function automatic logic [N_PROJ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_PROJ-1:0] v;
        v = '0;
        for (int i = 0; i < N_PROJ; i++) begin
            if (int'(id) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign sel_ready = !bus.disable_i && (state_q != GUARD);
    assign accept    = bus.sel_valid_i && sel_ready;
    assign id_ok     = (int'(bus.sel_id_i) < N_PROJ);

    guard_timer u_guard_timer (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .en_i   (tmr_en),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_nx   = state_q;
        active_nx  = active_q;
        cur_id_nx  = cur_id_q;
        cur_vld_nx = cur_vld_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = GUARD_LD;
        tmr_en     = 1'b0;

        // Disable wins over everything, including a request in the same cycle.
        if (bus.disable_i) begin
            state_nx   = IDLE;
            active_nx  = '0;
            cur_vld_nx = 1'b0;
            busy_nx    = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = '0;
        end else begin
            unique case (state_q)
                GUARD: begin
                    tmr_en = 1'b1;
                    if (tmr_zero) begin
                        state_nx   = RUN;
                        active_nx  = onehot(cur_id_q);
                        cur_vld_nx = 1'b1;
                        busy_nx    = 1'b0;
                        done_nx    = 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (!id_ok) begin
                            err_nx = 1'b1;
                        end else if ((state_q == RUN) && (bus.sel_id_i == cur_id_q)) begin
                            done_nx = 1'b1;
                        end else begin
                            // Drop the current owner first; the new one is enabled after the guard.
                            state_nx   = GUARD;
                            active_nx  = '0;
                            cur_id_nx  = bus.sel_id_i;
                            cur_vld_nx = 1'b0;
                            busy_nx    = 1'b1;
                            tmr_load   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            active_q  <= '0;
            cur_id_q  <= '0;
            cur_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nx;
            active_q  <= active_nx;
            cur_id_q  <= cur_id_nx;
            cur_vld_q <= cur_vld_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            err_q     <= err_nx;
        end
    end

    assign bus.sel_ready_o = sel_ready;
    assign bus.active_o    = active_q;
    assign bus.cur_id_o    = cur_id_q;
    assign bus.cur_vld_o   = cur_vld_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: directed scenarios plus a random run, all
// compared every cycle against a remaining-guard-cycles model of the controller.
`timescale 1ns/1ps
module tb_project_select_ctrl;

    localparam int N_PROJ    = 8;
    localparam int ID_W      = 4;
    localparam int GUARD_CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model state: active project (-1 none), pending/current id, guard cycles still to run.
    int m_act  = -1;
    int m_cur  = 0;
    int m_left = 0;
    int m_done = 0;
    int m_err  = 0;
    logic [N_PROJ-1:0] prev_active = '0;

    project_select_ctrl_if #(.N_PROJ(N_PROJ), .ID_W(ID_W)) bus ();

    project_select_ctrl #(
        .N_PROJ    (N_PROJ),
        .ID_W      (ID_W),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input int id, input logic d);
        @(posedge clk);
        #2;
        bus.sel_valid_i = v;
        bus.sel_id_i    = ID_W'(id);
        bus.disable_i   = d;
        #1;
    endtask

    function automatic logic [N_PROJ-1:0] model_active();
        if (m_act < 0) return '0;
        return N_PROJ'(1) << m_act;
    endfunction

    // Compare process: outputs of the last edge vs model, then advance model for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = -1; m_cur = 0; m_left = 0; m_done = 0; m_err = 0;
            end
            chk("active",  32'(bus.active_o),  32'(model_active()));
            chk("cur_id",  32'(bus.cur_id_o),  32'(m_cur));
            chk("cur_vld", 32'(bus.cur_vld_o), 32'(m_act >= 0));
            chk("busy",    32'(bus.busy_o),    32'(m_left > 0));
            chk("done",    32'(bus.done_o),    32'(m_done));
            chk("err",     32'(bus.err_o),     32'(m_err));
            chk("onehot0", 32'($countones(bus.active_o) <= 1), 32'(1));
            if (prev_active != '0 && bus.active_o != '0)
                chk("no_hop", 32'(bus.active_o), 32'(prev_active));
            prev_active = bus.active_o;
            if (rst_n) begin
                chk("ready", 32'(bus.sel_ready_o), 32'(!bus.disable_i && m_left == 0));
                m_done = 0;
                m_err  = 0;
                if (bus.disable_i) begin
                    m_act  = -1;
                    m_left = 0;
                end else if (m_left > 0) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_act  = m_cur;
                        m_done = 1;
                    end
                end else if (bus.sel_valid_i) begin
                    if (int'(bus.sel_id_i) >= N_PROJ) m_err = 1;
                    else if (m_act == int'(bus.sel_id_i)) m_done = 1;
                    else begin
                        m_act  = -1;
                        m_cur  = int'(bus.sel_id_i);
                        m_left = GUARD_CYC;
                    end
                end
            end
        end
    end

    initial begin
        bus.sel_valid_i = 1'b0;
        bus.sel_id_i    = '0;
        bus.disable_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_active", 32'(bus.active_o), 32'h0);
        chk("rst_ready",  32'(bus.sel_ready_o), 32'h1);
        chk("rst_done",   32'(bus.done_o), 32'h0);
        chk("rst_err",    32'(bus.err_o), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 1'b0);
            chk("idle_active", 32'(bus.active_o), 32'h0);
        end

        // IDLE -> id 3
        step(1'b1, 3, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 0, 1'b0);
            chk("g3_busy",   32'(bus.busy_o), 32'h1);
            chk("g3_active", 32'(bus.active_o), 32'h0);
        end
        step(1'b0, 0, 1'b0);
        chk("run3_active", 32'(bus.active_o), 32'h08);
        chk("run3_done",   32'(bus.done_o), 32'h1);
        chk("run3_busy",   32'(bus.busy_o), 32'h0);
        step(1'b0, 0, 1'b0);
        chk("run3_done_clr", 32'(bus.done_o), 32'h0);

        // id 3 -> id 5
        step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("sw5_gap", 32'(bus.active_o), 32'h0);
        chk("sw5_cur", 32'(bus.cur_id_o), 32'h5);
        repeat (3) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("run5_active", 32'(bus.active_o), 32'h20);

        // invalid id, then same-id no-op
        step(1'b1, 9, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("bad_err",    32'(bus.err_o), 32'h1);
        chk("bad_active", 32'(bus.active_o), 32'h20);
        step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("same_done",   32'(bus.done_o), 32'h1);
        chk("same_active", 32'(bus.active_o), 32'h20);
        chk("same_busy",   32'(bus.busy_o), 32'h0);

        // disable during GUARD with request held
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b1);
        chk("dis_ready", 32'(bus.sel_ready_o), 32'h0);
        step(1'b1, 2, 1'b1);
        chk("dis_active", 32'(bus.active_o), 32'h0);
        chk("dis_busy",   32'(bus.busy_o), 32'h0);
        chk("dis_done",   32'(bus.done_o), 32'h0);
        chk("dis_cur",    32'(bus.cur_id_o), 32'h2);
        step(1'b0, 0, 1'b0);
        chk("dis_noacc", 32'(bus.busy_o), 32'h0);

        // async reset mid-GUARD
        step(1'b1, 6, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("pre_rst_busy", 32'(bus.busy_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(bus.busy_o), 32'h0);
        chk("arst_cur",    32'(bus.cur_id_o), 32'h0);
        chk("arst_active", 32'(bus.active_o), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            step(1'b0, 0, 1'b0);
            chk("post_rst_active", 32'(bus.active_o), 32'h0);
        end

        // random run
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst_n           = ($urandom_range(0, 299) != 0);
            bus.sel_valid_i = $urandom_range(0, 1) == 1;
            bus.sel_id_i    = ID_W'($urandom_range(0, 10));
            bus.disable_i   = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        #2;
        rst_n           = 1'b1;
        bus.sel_valid_i = 1'b0;
        bus.disable_i   = 1'b0;
        repeat (8) @(posedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
